// File: rtl/seq_div_op.sv
// Multi-cycle radix-2 restoring divider: signed or unsigned A / B producing
// a truncated quotient and a dividend-signed remainder after a fixed N+2 cycles.
module seq_div_op #(
  parameter int N = 64,
  parameter int M = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         S0,
  input  logic [N-1:0] A,
  input  logic [M-1:0] B,
  output logic         BUSY,
  output logic         VALID,
  output logic [N-1:0] Q,
  output logic [M-1:0] R,
  output logic         DIV0,
  output logic         OVF
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [M:0]    p_reg;   // partial remainder
  logic [N-1:0]  d_reg;   // dividend shifting out, quotient shifting in
  logic [M-1:0]  b_mag;
  logic          sign_q;
  logic          sign_r;
  logic          div0_case;
  logic          ovf_case;

  logic [N-1:0]  a_mag_in;
  logic [M-1:0]  b_mag_in;
  logic          a_min;
  logic          b_neg_one;
  logic [M+1:0]  shifted;
  logic [M+1:0]  trial;

  // Magnitudes use wrap-around negation, so -2^(N-1) maps onto 2^(N-1).
  always_comb begin
    a_mag_in  = (S0 && A[N-1]) ? -A : A;
    b_mag_in  = (S0 && B[M-1]) ? -B : B;
    a_min     = (A == {1'b1, {(N-1){1'b0}}});
    b_neg_one = &B;
    shifted   = {p_reg, d_reg[N-1]};
    trial     = shifted - {2'b00, b_mag};
  end

  // NOTE: every register here, datapath included, is cleared by the
  // synchronous reset so an aborted operation leaves nothing behind.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      p_reg     <= '0;
      d_reg     <= '0;
      b_mag     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      div0_case <= 1'b0;
      ovf_case  <= 1'b0;
      BUSY      <= 1'b0;
      VALID     <= 1'b0;
      Q         <= '0;
      R         <= '0;
      DIV0      <= 1'b0;
      OVF       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so BUSY/VALID see the state
      // before this edge's transition and lag it by exactly one cycle.
      BUSY  <= (state != IDLE);
      VALID <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (START) begin
            d_reg     <= a_mag_in;
            b_mag     <= b_mag_in;
            p_reg     <= '0;
            cnt       <= CW'(N - 1);
            sign_q    <= S0 & (A[N-1] ^ B[M-1]);
            sign_r    <= S0 & A[N-1];
            div0_case <= (B == '0);
            ovf_case  <= S0 & a_min & b_neg_one;
            state     <= CALC;
          end
        end
        CALC: begin
          d_reg <= {d_reg[N-2:0], ~trial[M+1]};
          p_reg <= trial[M+1] ? shifted[M:0] : trial[M:0];
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CW'(1);
        end
        FIX: begin
          DIV0 <= div0_case;
          OVF  <= ovf_case;
          if (div0_case) begin
            Q <= '1;
            R <= '0;
          end else if (ovf_case) begin
            Q <= {1'b1, {(N-1){1'b0}}};
            R <= '0;
          end else begin
            Q <= sign_q ? -d_reg : d_reg;
            R <= sign_r ? -p_reg[M-1:0] : p_reg[M-1:0];
          end
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_op.sv
// Bench for seq_div_op: directed table, handshake/abort sequences and random
// operations on an 8/8 and a 64/32 instance against an arithmetic reference.
module tb_seq_div_op;

  logic clk;
  logic rst;

  logic        start8, s0_8, busy8, valid8, div0_8, ovf8;
  logic [7:0]  a8, b8, q8, r8;

  logic        start64, s0_64, busy64, valid64, div0_64, ovf64;
  logic [63:0] a64, q64;
  logic [31:0] b64, r64;

  int total = 0;
  int bad   = 0;

  seq_div_op #(.N(8), .M(8)) dut8 (
    .CLK(clk), .RST(rst), .START(start8), .S0(s0_8), .A(a8), .B(b8),
    .BUSY(busy8), .VALID(valid8), .Q(q8), .R(r8), .DIV0(div0_8), .OVF(ovf8)
  );

  seq_div_op #(.N(64), .M(32)) dut64 (
    .CLK(clk), .RST(rst), .START(start64), .S0(s0_64), .A(a64), .B(b64),
    .BUSY(busy64), .VALID(valid64), .Q(q64), .R(r64), .DIV0(div0_64), .OVF(ovf64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         s0;
    logic [7:0] a, b, q, r;
    bit         div0, ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: divide magnitudes with the language operators, then re-sign.
  task automatic ref_div(input int n, input int m, input bit s0,
                         input logic [63:0] a_in, input logic [63:0] b_in,
                         output logic [63:0] q, output logic [63:0] r,
                         output bit div0, output bit ovf);
    logic [63:0] a, b, am, bm;
    bit an, bn;
    a = a_in & mask(n);
    b = b_in & mask(m);
    div0 = 1'b0;
    ovf  = 1'b0;
    if (b == 64'd0) begin
      q = mask(n);
      r = 64'd0;
      div0 = 1'b1;
    end else begin
      an = s0 && a[n-1];
      bn = s0 && b[m-1];
      am = an ? ((-a) & mask(n)) : a;
      bm = bn ? ((-b) & mask(m)) : b;
      q = am / bm;
      r = am % bm;
      if (an ^ bn) q = -q;
      if (an) r = -r;
      q = q & mask(n);
      r = r & mask(m);
      ovf = s0 && (a == (64'd1 << (n - 1))) && (b == mask(m));
    end
  endtask

  task automatic drive(input int which, input bit st, input bit s0,
                       input logic [63:0] a, input logic [63:0] b);
    if (which == 0) begin
      start8 = st; s0_8 = s0; a8 = a[7:0]; b8 = b[7:0]; start64 = 1'b0;
    end else begin
      start64 = st; s0_64 = s0; a64 = a; b64 = b[31:0]; start8 = 1'b0;
    end
  endtask

  task automatic sample(input int which, output bit busy, output bit valid,
                        output logic [63:0] q, output logic [63:0] r,
                        output bit div0, output bit ovf);
    if (which == 0) begin
      busy = busy8; valid = valid8; q = {56'd0, q8}; r = {56'd0, r8};
      div0 = div0_8; ovf = ovf8;
    end else begin
      busy = busy64; valid = valid64; q = q64; r = {32'd0, r64};
      div0 = div0_64; ovf = ovf64;
    end
  endtask

  // Called on a falling edge; returns on the falling edge where VALID is seen,
  // so an immediate second call issues a back-to-back START.
  task automatic do_op(input int which, input bit s0, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] eq,
                       input logic [63:0] er, input bit ediv0, input bit eovf,
                       input int intrude_at, input string tag);
    int n, lat, budget, cnt, busy_cnt;
    bit found, busy, valid, div0, ovf;
    logic [63:0] q, r;
    n        = (which == 0) ? 8 : 64;
    lat      = n + 2;
    budget   = n + 12;
    drive(which, 1'b1, s0, a, b);
    @(negedge clk);
    drive(which, 1'b0, 1'($urandom), rnd64(), rnd64());
    cnt      = 0;
    busy_cnt = 0;
    found    = 1'b0;
    while (!found && cnt < budget) begin
      sample(which, busy, valid, q, r, div0, ovf);
      if (busy) busy_cnt++;
      if (valid) found = 1'b1;
      else begin
        @(negedge clk);
        cnt++;
        drive(which, cnt == intrude_at, 1'($urandom), rnd64(), rnd64());
      end
    end
    check({tag, " latency"}, 64'(cnt), 64'(lat));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(lat));
    check({tag, " q"}, q, eq);
    check({tag, " r"}, r, er);
    check({tag, " div0"}, 64'(div0), 64'(ediv0));
    check({tag, " ovf"}, 64'(ovf), 64'(eovf));
  endtask

  task automatic rand_op(input int which);
    int n, m, sel;
    bit s0, ediv0, eovf;
    logic [63:0] a, b, eq, er;
    n   = (which == 0) ? 8 : 64;
    m   = (which == 0) ? 8 : 32;
    sel = $urandom_range(0, 15);
    s0  = 1'($urandom);
    a   = rnd64() & mask(n);
    b   = rnd64() & mask(m);
    if (sel == 0) b = 64'd0;
    else if (sel == 1) begin
      s0 = 1'b1;
      a  = 64'd1 << (n - 1);
      b  = mask(m);
    end else if (sel < 5) begin
      b = 64'($urandom_range(1, 5));
      if (sel == 4) b = (-b) & mask(m);
    end
    ref_div(n, m, s0, a, b, eq, er, ediv0, eovf);
    do_op(which, s0, a, b, eq, er, ediv0, eovf, -1, (which == 0) ? "rand8" : "rand64");
  endtask

  initial begin
    bit busy, valid, div0, ovf, saw;
    logic [63:0] q, r;

    vecs[0]  = '{1'b1, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h9C, 8'h07, 8'h16, 8'h02, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 8'h05, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0};

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      sample(w, busy, valid, q, r, div0, ovf);
      check("reset busy", 64'(busy), 64'd0);
      check("reset valid", 64'(valid), 64'd0);
      check("reset q", q, 64'd0);
      check("reset r", r, 64'd0);
      check("reset div0", 64'(div0), 64'd0);
      check("reset ovf", 64'(ovf), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back to back.
    for (int i = 0; i < 12; i++)
      do_op(0, vecs[i].s0, 64'(vecs[i].a), 64'(vecs[i].b), 64'(vecs[i].q),
            64'(vecs[i].r), vecs[i].div0, vecs[i].ovf, -1, $sformatf("vec%0d", i));

    // A second START three cycles in must not disturb the running operation.
    @(negedge clk);
    do_op(0, 1'b1, 64'd100, 64'd7, 64'h0E, 64'h02, 1'b0, 1'b0, 3, "intrude");

    // Reset four cycles into an operation, with a START alongside the reset.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 64'h9C, 64'h07);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 64'h64, 64'h07);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    sample(0, busy, valid, q, r, div0, ovf);
    check("abort busy", 64'(busy), 64'd0);
    check("abort valid", 64'(valid), 64'd0);
    check("abort q", q, 64'd0);
    check("abort r", r, 64'd0);
    check("abort div0", 64'(div0), 64'd0);
    check("abort ovf", 64'(ovf), 64'd0);
    saw = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (valid8 || busy8) saw = 1'b1;
    end
    check("abort no activity", 64'(saw), 64'd0);
    do_op(0, 1'b1, 64'h9C, 64'h07, 64'hF2, 64'hFE, 1'b0, 1'b0, -1, "after_reset");

    // 64/32 directed: most negative dividend by -1, and a plain signed case.
    @(negedge clk);
    do_op(1, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF,
          64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b1, -1, "w64_ovf");
    do_op(1, 1'b1, -64'd1000, 64'd7, -64'd142, 64'h0000_0000_FFFF_FFFA,
          1'b0, 1'b0, -1, "w64_neg");

    for (int i = 0; i < 1400; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rand_op(0);
    end
    for (int i = 0; i < 600; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rand_op(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
